// File: rtl/vga_scan_controller.sv
// vga_scan_controller: 640x480@60 raster generator with a pixel-step clock
// divider, latency-matched sync/blank pipeline, blank-gated RGB re-timing for
// the ADV7123 DAC, and a vertical-blank frame clock for the game controller.
module vga_scan_controller #(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned PIPE_LAT = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  iR,
    input  logic [7:0]  iG,
    input  logic [7:0]  iB,
    output logic [10:0] scanX,
    output logic [10:0] scanY,
    output logic        active,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_clock,
    output logic        frame_tick
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] Y_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] X_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] Y_VLAST  = 11'(V_ACTIVE - 1);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] divCnt;
    logic             pixEn;
    logic             lineEnd;
    logic             frameEnd;
    logic             vblankStart;
    logic             hsRaw;
    logic             vsRaw;

    // Stage k of each pipe holds the raw timing from k+1 pixel steps ago.
    logic [PIPE_LAT:0]   hsPipe;
    logic [PIPE_LAT:0]   vsPipe;
    logic [PIPE_LAT:0]   blPipe;
    // Tap 0 is the undelayed raw value, tap k is pipe stage k-1; this lets the
    // RGB gate look at the value entering the last stage even when PIPE_LAT=0.
    logic [PIPE_LAT+1:0] hsTap;
    logic [PIPE_LAT+1:0] vsTap;
    logic [PIPE_LAT+1:0] blTap;

    assign pixEn       = (divCnt == DIV_LAST);
    assign lineEnd     = (scanX == X_LAST);
    assign frameEnd    = lineEnd && (scanY == Y_LAST);
    assign vblankStart = lineEnd && (scanY == Y_VLAST);

    assign active = (scanX < X_ACT) && (scanY < Y_ACT);
    assign hsRaw  = !((scanX >= HS_START) && (scanX < HS_END));
    assign vsRaw  = !((scanY >= VS_START) && (scanY < VS_END));

    assign hsTap = {hsPipe, hsRaw};
    assign vsTap = {vsPipe, vsRaw};
    assign blTap = {blPipe, active};

    assign VGA_HS      = hsTap[PIPE_LAT+1];
    assign VGA_VS      = vsTap[PIPE_LAT+1];
    assign VGA_BLANK_N = blTap[PIPE_LAT+1];
    assign VGA_SYNC_N  = 1'b0;
    assign frame_tick  = pixEn && vblankStart;

    // Pixel-step divider and the DAC pixel clock derived from it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divCnt  <= '0;
            VGA_CLK <= 1'b0;
        end else begin
            divCnt  <= pixEn ? '0 : divCnt + 1'b1;
            VGA_CLK <= (divCnt >= DIV_HALF);
        end
    end

    // Raster position counters, advanced once per pixel step.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scanX <= '0;
            scanY <= '0;
        end else if (pixEn) begin
            if (lineEnd) begin
                scanX <= '0;
                scanY <= (scanY == Y_LAST) ? '0 : scanY + 11'd1;
            end else begin
                scanX <= scanX + 11'd1;
            end
        end
    end

    // Sync/blank delay line matching the game video path latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hsPipe <= '1;
            vsPipe <= '1;
            blPipe <= '0;
        end else if (pixEn) begin
            hsPipe <= hsTap[PIPE_LAT:0];
            vsPipe <= vsTap[PIPE_LAT:0];
            blPipe <= blTap[PIPE_LAT:0];
        end
    end

    // Register returned colour, zeroed when the aligned blank says invisible.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            VGA_R <= '0;
            VGA_G <= '0;
            VGA_B <= '0;
        end else if (pixEn) begin
            if (blTap[PIPE_LAT]) begin
                VGA_R <= iR;
                VGA_G <= iG;
                VGA_B <= iB;
            end else begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end
        end
    end

    // Frame clock: high from the start of vertical blank until frame wrap.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            frame_clock <= 1'b0;
        end else if (pixEn) begin
            if (vblankStart) begin
                frame_clock <= 1'b1;
            end else if (frameEnd) begin
                frame_clock <= 1'b0;
            end
        end
    end

endmodule
